// File: rtl/mem_line_responder.sv
// mem_line_responder: L1 line-interface memory model; clk, reset_n, read_i/write_i/adr_i/dat_i/sel_i in, dat_o/resp_o/busy_o/proto_err_o out
module mem_line_responder #(
  parameter int LATENCY    = 4,
  parameter int INDEX_BITS = 5
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         read_i,
  input  logic         write_i,
  input  logic [15:0]  adr_i,
  input  logic [127:0] dat_i,
  input  logic [15:0]  sel_i,
  output logic [127:0] dat_o,
  output logic         resp_o,
  output logic         busy_o,
  output logic         proto_err_o
);
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  state_t state, state_nx;
  logic [3:0] cnt;
  logic [INDEX_BITS-1:0] idx;
  logic [127:0] dat;
  logic [15:0] sel;
  logic op;
  logic [127:0] mem [2**INDEX_BITS];
  logic [127:0] merged;
  always_comb begin
    state_nx = state == IDLE ? ((read_i | write_i) ? WAIT : IDLE) :
               state == WAIT ? ((cnt == 4'd0) ? DONE : WAIT) : IDLE;
  end
  always_comb begin
    merged = mem[idx];
    for (int i = 0; i < 16; i++)
      merged[8*i +: 8] = sel[i] ? dat[8*i +: 8] : merged[8*i +: 8];
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      cnt         <= '0;
      idx         <= '0;
      dat         <= '0;
      sel         <= '0;
      op          <= 1'b0;
      proto_err_o <= 1'b0;
      dat_o       <= '0;
      for (int i = 0; i < 2**INDEX_BITS; i++)
        mem[i] <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && (read_i | write_i)) begin
        idx         <= adr_i[4 +: INDEX_BITS];
        dat         <= dat_i;
        sel         <= sel_i;
        op          <= write_i;
        cnt         <= 4'(LATENCY - 1);
        proto_err_o <= proto_err_o | (read_i & write_i);
      end
      if (state == WAIT) begin
        if (cnt != 4'd0)
          cnt <= cnt - 4'd1;
        else if (op)
          mem[idx] <= merged;
        else
          dat_o <= mem[idx];
      end
    end
  end
  assign resp_o = state == DONE;
  assign busy_o = state != IDLE;
endmodule
